// File: rtl/clock_gen.sv
// Clock divider / pulse generator: power-of-two, even /DIV_EVEN, odd /5 and a strobe-modulated counter.
// Define CLOCK_GEN_DIV5_50PCT_EN for the dual-edge 50%-duty divide-by-5 output.
`timescale 1ns/1ps

module clock_gen #(
  parameter int DIV_EVEN      = 28,
  parameter int STROBE_PERIOD = 4,
  parameter int GC_INC        = 2,
  parameter int GC_DEC        = 5
) (
  input  logic       clk_in,
  input  logic       rst,
  output logic       clk_div_2,
  output logic       clk_div_4,
  output logic       clk_div_8,
  output logic       clk_div_16,
  output logic       clk_div_28,
  output logic       clk_div_5,
  output logic [7:0] glitchy_counter
);

  localparam int HALF = DIV_EVEN / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = (STROBE_PERIOD > 1) ? $clog2(STROBE_PERIOD) : 1;

  localparam logic [DW-1:0] D_MAX = DW'(HALF - 1);
  localparam logic [SW-1:0] S_MAX = SW'(STROBE_PERIOD - 1);
  localparam logic [7:0]    INC   = 8'(GC_INC);
  localparam logic [7:0]    DEC   = 8'(GC_DEC);

  logic [3:0]    c_q, c_d;
  logic [DW-1:0] d_q, d_d;
  logic          div28_q, div28_d;
  logic [2:0]    p_q, p_d;
  logic          pos_q, pos_d;
  logic [SW-1:0] s_q, s_d;
  logic [7:0]    gc_q, gc_d;
  logic          strobe;

  always_comb begin
    c_d     = c_q + 4'd1;
    d_d     = d_q + DW'(1);
    div28_d = div28_q;
    p_d     = p_q + 3'd1;
    s_d     = s_q + SW'(1);
    strobe  = (s_q == S_MAX);
    gc_d    = gc_q + INC;

    if (d_q == D_MAX) begin
      d_d     = '0;
      div28_d = ~div28_q;
    end

    if (p_q == 3'd4) begin
      p_d = 3'd0;
    end
    // High for the two posedge slots p==4 and p==0 of each five-cycle period
    pos_d = (p_q == 3'd4) || (p_q == 3'd0);

    if (s_q == S_MAX) begin
      s_d = '0;
    end

    if (strobe) begin
      gc_d = gc_q - DEC;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      div28_q <= 1'b0;
      p_q     <= '0;
      pos_q   <= 1'b0;
      s_q     <= '0;
      gc_q    <= '0;
    end else begin
      c_q     <= c_d;
      d_q     <= d_d;
      div28_q <= div28_d;
      p_q     <= p_d;
      pos_q   <= pos_d;
      s_q     <= s_d;
      gc_q    <= gc_d;
    end
  end

`ifdef CLOCK_GEN_DIV5_50PCT_EN
  // Half-cycle delayed copy of pos_q stretches the pulse to 2.5 input cycles
  logic neg_q, neg_d;

  always_comb begin
    neg_d = pos_q;
  end

  always_ff @(negedge clk_in) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign clk_div_5 = pos_q | neg_q;
`else
  assign clk_div_5 = pos_q;
`endif

  assign clk_div_2       = c_q[0];
  assign clk_div_4       = c_q[1];
  assign clk_div_8       = c_q[2];
  assign clk_div_16      = c_q[3];
  assign clk_div_28      = div28_q;
  assign glitchy_counter = gc_q;

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: arithmetic model over the posedge count since reset,
// plus literal checks of the start-up sequences, edge timing and mid-run reset.
`timescale 1ns/1ps

module tb_clock_gen;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_28, clk_div_5;
  logic [7:0] glitchy_counter;

  int vectors     = 0;
  int miscompares = 0;

  clock_gen dut (
    .clk_in          (clk_in),
    .rst             (rst),
    .clk_div_2       (clk_div_2),
    .clk_div_4       (clk_div_4),
    .clk_div_8       (clk_div_8),
    .clk_div_16      (clk_div_16),
    .clk_div_28      (clk_div_28),
    .clk_div_5       (clk_div_5),
    .glitchy_counter (glitchy_counter)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: k = posedges since the last sampled reset; outputs follow from k arithmetically
  int   k = 0;
  int   cycles = 0;
  logic neg_m = 1'b0;

  function automatic logic pos_m(input int n);
    return (n >= 1) && ((n % 5 == 0) || (n % 5 == 1));
  endfunction

  function automatic logic [7:0] gc_m(input int n);
    return 8'((2 * n - 7 * (n / 4)) % 256);
  endfunction

  function automatic logic div5_m();
`ifdef CLOCK_GEN_DIV5_50PCT_EN
    return pos_m(k) | neg_m;
`else
    return pos_m(k);
`endif
  endfunction

  always @(posedge clk_in) begin
    if (rst) k = 0;
    else     k = k + 1;
    cycles++;
    #1;
    if (cycles >= 2) begin
      check_output("div2",   32'(clk_div_2),       32'((k / 1) % 2));
      check_output("div4",   32'(clk_div_4),       32'((k / 2) % 2));
      check_output("div8",   32'(clk_div_8),       32'((k / 4) % 2));
      check_output("div16",  32'(clk_div_16),      32'((k / 8) % 2));
      check_output("div28",  32'(clk_div_28),      32'((k / 14) % 2));
      check_output("div5_p", 32'(clk_div_5),       32'(div5_m()));
      check_output("gc",     32'(glitchy_counter), 32'(gc_m(k)));
    end
  end

  always @(negedge clk_in) begin
    neg_m = rst ? 1'b0 : pos_m(k);
    #1;
    if (cycles >= 2) begin
      check_output("div5_n", 32'(clk_div_5), 32'(div5_m()));
    end
  end

  // Edge-to-edge measurement on a selectable output
  int   meas_sel = 0;
  logic meas_sig;
  assign meas_sig = (meas_sel == 0) ? clk_div_5 : (meas_sel == 1) ? clk_div_8 : clk_div_16;

  task automatic measure(input int sel, input string name, input int exp_hi, input int exp_lo);
    realtime t0, t1, t2;
    bit done;
    done = 1'b0;
    t0 = 0; t1 = 0; t2 = 0;
    meas_sel = sel;
    fork
      begin
        @(posedge meas_sig); t0 = $realtime;
        @(negedge meas_sig); t1 = $realtime;
        @(posedge meas_sig); t2 = $realtime;
        done = 1'b1;
      end
      begin
        #500;
      end
    join_any
    disable fork;
    check_output({name, "_done"}, 32'(done), 32'd1);
    if (done) begin
      check_output({name, "_high_ns"}, 32'(int'(t1 - t0)), 32'(exp_hi));
      check_output({name, "_low_ns"},  32'(int'(t2 - t1)), 32'(exp_lo));
    end
  endtask

  task automatic check_zero(input string name);
    check_output({name, "_all"},
                 32'({clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_28, clk_div_5, glitchy_counter}),
                 32'd0);
  endtask

  logic [7:0] gc_lit   [12] = '{8'd2, 8'd4, 8'd6, 8'd1, 8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd8, 8'd3};
  logic       div2_lit [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       div4_lit [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

  task automatic apply_stimulus();
    bit reached;
    rst = 1'b1;
    repeat (8) @(posedge clk_in);
    #1;
    check_zero("reset");
    #1 rst = 1'b0;

    for (int i = 1; i <= 64; i++) begin
      @(posedge clk_in);
      #1;
      if (i <= 4) begin
        check_output("lit_div2", 32'(clk_div_2), 32'(div2_lit[i-1]));
        check_output("lit_div4", 32'(clk_div_4), 32'(div4_lit[i-1]));
      end
      if (i <= 12) check_output("lit_gc", 32'(glitchy_counter), 32'(gc_lit[i-1]));
      if (i == 7)  check_output("lit_div16_7", 32'(clk_div_16), 32'd0);
      if (i == 8)  check_output("lit_div16_8", 32'(clk_div_16), 32'd1);
      if (i == 13) check_output("lit_div28_13", 32'(clk_div_28), 32'd0);
      if (i == 14) check_output("lit_div28_14", 32'(clk_div_28), 32'd1);
      if (i == 27) check_output("lit_div28_27", 32'(clk_div_28), 32'd1);
      if (i == 28) check_output("lit_div28_28", 32'(clk_div_28), 32'd0);
      if (i == 42) check_output("lit_div28_42", 32'(clk_div_28), 32'd1);
    end

`ifdef CLOCK_GEN_DIV5_50PCT_EN
    measure(0, "div5", 25, 25);
`else
    measure(0, "div5", 20, 30);
`endif
    measure(1, "div8", 40, 40);
    measure(2, "div16", 80, 80);

    // 1024 posedges: 2*1024 - 7*256 = 256, so the counter is back at 0
    reached = 1'b0;
    for (int n = 0; n < 2000 && !reached; n++) begin
      @(posedge clk_in);
      #1;
      if (k == 1024) reached = 1'b1;
    end
    check_output("reach_1024", 32'(reached), 32'd1);
    if (reached) begin
      check_output("lit_gc_1024",    32'(glitchy_counter), 32'd0);
      check_output("lit_div28_1024", 32'(clk_div_28),      32'd1);
    end

    #1 rst = 1'b1;
    @(posedge clk_in);
    #1;
    check_zero("reset_a");
    #1 rst = 1'b0;
    repeat (7) @(posedge clk_in);
    #1;
    check_output("lit_gc_7", 32'(glitchy_counter), 32'd7);
    #1 rst = 1'b1;
    @(posedge clk_in);
    #1;
    check_zero("reset_mid");
    @(posedge clk_in);
    #1 rst = 1'b0;
    @(posedge clk_in);
    #1;
    check_output("restart_gc",   32'(glitchy_counter), 32'd2);
    check_output("restart_div2", 32'(clk_div_2),       32'd1);
    repeat (20) @(posedge clk_in);
  endtask

  initial begin
    apply_stimulus();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
